// File: rtl/cache_pkg.sv
// Shared types, geometry and address helpers for the L1 controller slice.
`ifndef ADDR_BITS
`define ADDR_BITS 32
`endif
`ifndef OFFSET_BITS
`define OFFSET_BITS 4
`endif
`ifndef L1_INDEX_BITS
`define L1_INDEX_BITS 2
`endif

package cache_pkg;

    localparam int unsigned ADDR_BITS      = `ADDR_BITS;
    localparam int unsigned OFFSET_BITS    = `OFFSET_BITS;
    localparam int unsigned INDEX_BITS     = `L1_INDEX_BITS;
    localparam int unsigned LINE_ADDR_BITS = ADDR_BITS - OFFSET_BITS;
    localparam int unsigned TAG_BITS       = LINE_ADDR_BITS - INDEX_BITS;
    localparam int unsigned LINE_BITS      = 8 << OFFSET_BITS;

    // Zero encoding is I so a cleared array reads as all-invalid.
    typedef enum logic [1:0] {
        I = 2'd0,
        S = 2'd1,
        M = 2'd2
    } l1_state_t;

    typedef struct packed {
        l1_state_t             state;
        logic [TAG_BITS-1:0]   tag;
        logic [LINE_BITS-1:0]  data;
    } l1_cacheline_t;

    typedef enum logic [1:0] {
        BUS_RD  = 2'd0,
        BUS_RDX = 2'd1,
        BUS_WB  = 2'd2
    } bus_cmd_t;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LOOKUP    = 3'd1,
        WB        = 3'd2,
        MISS_REQ  = 3'd3,
        MISS_WAIT = 3'd4,
        RESP      = 3'd5
    } l1_ctrl_state_t;

    function automatic logic [TAG_BITS-1:0] tag_of(input logic [LINE_ADDR_BITS-1:0] line_addr);
        return line_addr[LINE_ADDR_BITS-1:INDEX_BITS];
    endfunction

    function automatic logic [INDEX_BITS-1:0] index_of(input logic [LINE_ADDR_BITS-1:0] line_addr);
        return line_addr[INDEX_BITS-1:0];
    endfunction

endpackage

// File: rtl/l1_word_mux.sv
// Word extract from, and word insert into, a cache line at a word select.
module l1_word_mux
    import cache_pkg::*;
#(
    parameter int unsigned WORD_BITS = 32,
    parameter int unsigned WSEL_BITS = 2
) (
    input  logic [LINE_BITS-1:0]  line_in,
    input  logic [WSEL_BITS-1:0]  sel,
    input  logic [WORD_BITS-1:0]  word_in,
    output logic [WORD_BITS-1:0]  word_out,
    output logic [LINE_BITS-1:0]  line_out
);

    always_comb begin
        word_out = line_in[sel*WORD_BITS +: WORD_BITS];
        line_out = line_in;
        line_out[sel*WORD_BITS +: WORD_BITS] = word_in;
    end

endmodule

// File: rtl/l1_ctrl.sv
// Processor-side L1 controller: lookup, store merge, M-victim writeback and
// MSI miss handling over the shared bus, one request outstanding.
module l1_ctrl
    import cache_pkg::*;
#(
    parameter int unsigned WORD_BITS = 32
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      cpu_req_valid,
    output logic                      cpu_req_ready,
    input  logic                      cpu_req_we,
    input  logic [ADDR_BITS-1:0]      cpu_req_addr,
    input  logic [WORD_BITS-1:0]      cpu_req_wdata,
    output logic                      cpu_rsp_valid,
    output logic [WORD_BITS-1:0]      cpu_rsp_rdata,
    output logic [LINE_ADDR_BITS-1:0] addr_ctrl,
    input  l1_cacheline_t             cacheline_ctrl_out,
    output l1_cacheline_t             cacheline_ctrl_in,
    output logic                      ctrl_valid,
    output logic                      bus_req,
    input  logic                      bus_gnt,
    output bus_cmd_t                  bus_cmd,
    output logic [LINE_ADDR_BITS-1:0] bus_addr,
    output logic [LINE_BITS-1:0]      bus_wdata,
    input  logic                      bus_rsp_valid,
    input  logic [LINE_BITS-1:0]      bus_rsp_data
);

    localparam int unsigned BYTE_SEL_BITS = $clog2(WORD_BITS / 8);
    localparam int unsigned WSEL_BITS     = OFFSET_BITS - BYTE_SEL_BITS;

    l1_ctrl_state_t state, state_d;

    logic                      req_we;
    logic [LINE_ADDR_BITS-1:0] req_line;
    logic [WSEL_BITS-1:0]      req_wsel;
    logic [WORD_BITS-1:0]      req_wdata;
    logic [TAG_BITS-1:0]       victim_tag;
    logic [WORD_BITS-1:0]      rdata_q;

    logic                      accept;
    logic                      take_victim;
    logic                      load_word;
    logic [LINE_BITS-1:0]      mux_src;
    logic [WORD_BITS-1:0]      word_out;
    logic [LINE_BITS-1:0]      merged;
    logic [TAG_BITS-1:0]       req_tag;
    logic [INDEX_BITS-1:0]     req_index;
    logic                      hit;
    logic                      unused_byte_bits;

    assign req_tag          = tag_of(req_line);
    assign req_index        = index_of(req_line);
    assign hit              = (cacheline_ctrl_out.state != I) && (cacheline_ctrl_out.tag == req_tag);
    assign unused_byte_bits = ^cpu_req_addr[BYTE_SEL_BITS-1:0];

    // One mux serves the hit path (array data) and the fill path (bus data).
    l1_word_mux #(
        .WORD_BITS (WORD_BITS),
        .WSEL_BITS (WSEL_BITS)
    ) u_word_mux (
        .line_in  (mux_src),
        .sel      (req_wsel),
        .word_in  (req_wdata),
        .word_out (word_out),
        .line_out (merged)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_d;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            req_we     <= 1'b0;
            req_line   <= '0;
            req_wsel   <= '0;
            req_wdata  <= '0;
            victim_tag <= '0;
            rdata_q    <= '0;
        end else begin
            if (accept) begin
                req_we    <= cpu_req_we;
                req_line  <= cpu_req_addr[ADDR_BITS-1:OFFSET_BITS];
                req_wsel  <= cpu_req_addr[OFFSET_BITS-1:BYTE_SEL_BITS];
                req_wdata <= cpu_req_wdata;
                rdata_q   <= '0;
            end
            if (take_victim) victim_tag <= cacheline_ctrl_out.tag;
            if (load_word)   rdata_q    <= word_out;
        end
    end

    always_comb begin
        state_d           = state;
        accept            = 1'b0;
        take_victim       = 1'b0;
        load_word         = 1'b0;
        mux_src           = cacheline_ctrl_out.data;
        cpu_req_ready     = 1'b0;
        cpu_rsp_valid     = 1'b0;
        cpu_rsp_rdata     = '0;
        addr_ctrl         = req_line;
        cacheline_ctrl_in = '0;
        ctrl_valid        = 1'b0;
        bus_req           = 1'b0;
        bus_cmd           = BUS_RD;
        bus_addr          = '0;
        bus_wdata         = '0;

        case (state)
            IDLE: begin
                cpu_req_ready = 1'b1;
                addr_ctrl     = '0;
                if (cpu_req_valid) begin
                    accept  = 1'b1;
                    state_d = LOOKUP;
                end
            end
            LOOKUP: begin
                if (hit && !req_we) begin
                    load_word = 1'b1;
                    state_d   = RESP;
                end else if (hit && cacheline_ctrl_out.state == M) begin
                    ctrl_valid              = 1'b1;
                    cacheline_ctrl_in.state = M;
                    cacheline_ctrl_in.tag   = cacheline_ctrl_out.tag;
                    cacheline_ctrl_in.data  = merged;
                    state_d                 = RESP;
                end else if (cacheline_ctrl_out.state == M && cacheline_ctrl_out.tag != req_tag) begin
                    take_victim = 1'b1;
                    state_d     = WB;
                end else begin
                    state_d = MISS_REQ;
                end
            end
            WB: begin
                // A snoop may have flushed or downgraded the victim meanwhile.
                if (cacheline_ctrl_out.state == M && cacheline_ctrl_out.tag == victim_tag) begin
                    bus_req   = 1'b1;
                    bus_cmd   = BUS_WB;
                    bus_addr  = {victim_tag, req_index};
                    bus_wdata = cacheline_ctrl_out.data;
                    if (bus_gnt) begin
                        ctrl_valid              = 1'b1;
                        cacheline_ctrl_in       = cacheline_ctrl_out;
                        cacheline_ctrl_in.state = I;
                        state_d                 = MISS_REQ;
                    end
                end else begin
                    state_d = MISS_REQ;
                end
            end
            MISS_REQ: begin
                bus_req  = 1'b1;
                bus_cmd  = req_we ? BUS_RDX : BUS_RD;
                bus_addr = req_line;
                if (bus_gnt) state_d = MISS_WAIT;
            end
            MISS_WAIT: begin
                mux_src = bus_rsp_data;
                if (bus_rsp_valid) begin
                    ctrl_valid              = 1'b1;
                    cacheline_ctrl_in.state = req_we ? M : S;
                    cacheline_ctrl_in.tag   = req_tag;
                    cacheline_ctrl_in.data  = req_we ? merged : bus_rsp_data;
                    load_word               = !req_we;
                    state_d                 = RESP;
                end
            end
            RESP: begin
                cpu_rsp_valid = 1'b1;
                cpu_rsp_rdata = rdata_q;
                state_d       = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_l1_ctrl.sv
// Directed bench for l1_ctrl with a 4-line array model, snoop hook and bus model.
module tb_l1_ctrl;
    import cache_pkg::*;

    logic                      clk = 1'b0;
    logic                      reset_n = 1'b0;
    logic                      cpu_req_valid = 1'b0;
    logic                      cpu_req_ready;
    logic                      cpu_req_we = 1'b0;
    logic [ADDR_BITS-1:0]      cpu_req_addr = '0;
    logic [31:0]               cpu_req_wdata = '0;
    logic                      cpu_rsp_valid;
    logic [31:0]               cpu_rsp_rdata;
    logic [LINE_ADDR_BITS-1:0] addr_ctrl;
    l1_cacheline_t             cacheline_ctrl_out;
    l1_cacheline_t             cacheline_ctrl_in;
    logic                      ctrl_valid;
    logic                      bus_req;
    logic                      bus_gnt = 1'b0;
    bus_cmd_t                  bus_cmd;
    logic [LINE_ADDR_BITS-1:0] bus_addr;
    logic [LINE_BITS-1:0]      bus_wdata;
    logic                      bus_rsp_valid = 1'b0;
    logic [LINE_BITS-1:0]      bus_rsp_data = '0;

    l1_cacheline_t             arr [4] = '{default: '0};
    logic                      snoop_we = 1'b0;
    logic [1:0]                snoop_idx = '0;
    l1_cacheline_t             snoop_line = '0;

    int n_vec = 0;
    int n_bad = 0;
    int n_req_cyc = 0;
    int n_wb_iss = 0;

    localparam logic [127:0] FILL1 = {32'h3333_0003, 32'h2222_0002, 32'hA5A5_0001, 32'h1111_0000};
    localparam logic [127:0] D_RDX = {32'h3333_0003, 32'hDEAD_BEEF, 32'hA5A5_0001, 32'h1111_0000};
    localparam logic [127:0] D_HIT = {32'h0000_1234, 32'hDEAD_BEEF, 32'hA5A5_0001, 32'h1111_0000};
    localparam logic [127:0] FILL3 = {32'h4444_0003, 32'h4444_0002, 32'h4444_0001, 32'h4444_0000};
    localparam logic [127:0] D_ST6 = {32'h4444_0003, 32'h4444_0002, 32'h5555_5555, 32'h4444_0000};

    l1_ctrl #(.WORD_BITS(32)) dut (
        .clk                (clk),
        .reset_n            (reset_n),
        .cpu_req_valid      (cpu_req_valid),
        .cpu_req_ready      (cpu_req_ready),
        .cpu_req_we         (cpu_req_we),
        .cpu_req_addr       (cpu_req_addr),
        .cpu_req_wdata      (cpu_req_wdata),
        .cpu_rsp_valid      (cpu_rsp_valid),
        .cpu_rsp_rdata      (cpu_rsp_rdata),
        .addr_ctrl          (addr_ctrl),
        .cacheline_ctrl_out (cacheline_ctrl_out),
        .cacheline_ctrl_in  (cacheline_ctrl_in),
        .ctrl_valid         (ctrl_valid),
        .bus_req            (bus_req),
        .bus_gnt            (bus_gnt),
        .bus_cmd            (bus_cmd),
        .bus_addr           (bus_addr),
        .bus_wdata          (bus_wdata),
        .bus_rsp_valid      (bus_rsp_valid),
        .bus_rsp_data       (bus_rsp_data)
    );

    always #5 clk = ~clk;

    // Array: controller writes win; a snoop write is visible on the read port in its own cycle.
    assign cacheline_ctrl_out = (snoop_we && snoop_idx == addr_ctrl[1:0]) ? snoop_line : arr[addr_ctrl[1:0]];

    always @(posedge clk) begin
        if (ctrl_valid)    arr[addr_ctrl[1:0]] <= cacheline_ctrl_in;
        else if (snoop_we) arr[snoop_idx]      <= snoop_line;
        if (bus_req) n_req_cyc <= n_req_cyc + 1;
        if (bus_req && bus_gnt && bus_cmd == BUS_WB) n_wb_iss <= n_wb_iss + 1;
    end

    task automatic chk(input string tag, input logic [159:0] got, input logic [159:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic l1_cacheline_t mk_line(input l1_state_t st, input logic [TAG_BITS-1:0] tg,
                                              input logic [LINE_BITS-1:0] d);
        l1_cacheline_t l;
        l.state = st;
        l.tag   = tg;
        l.data  = d;
        return l;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench one edge after accept, i.e. in LOOKUP.
    task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wd);
        chk("req_ready", 160'(cpu_req_ready), 160'(1));
        cpu_req_valid = 1'b1;
        cpu_req_we    = we;
        cpu_req_addr  = addr;
        cpu_req_wdata = wd;
        tick();
        cpu_req_valid = 1'b0;
        #1;
        chk("busy_ready", 160'(cpu_req_ready), 160'(0));
    endtask

    task automatic wait_bus(input string tag, input bus_cmd_t cmd, input logic [LINE_ADDR_BITS-1:0] addr);
        int n = 0;
        while (!bus_req && n < 16) begin
            tick();
            n++;
        end
        chk({tag, "_req"}, 160'(bus_req), 160'(1));
        chk({tag, "_cmd"}, 160'(bus_cmd), 160'(cmd));
        chk({tag, "_addr"}, 160'(bus_addr), 160'(addr));
    endtask

    task automatic grant();
        bus_gnt = 1'b1;
        tick();
        bus_gnt = 1'b0;
        #1;
    endtask

    task automatic fill(input string tag, input logic [LINE_BITS-1:0] d, input l1_cacheline_t exp_line,
                        input logic [31:0] exp_rdata);
        bus_rsp_valid = 1'b1;
        bus_rsp_data  = d;
        #1;
        chk({tag, "_fill_we"}, 160'(ctrl_valid), 160'(1));
        chk({tag, "_fill_line"}, 160'(cacheline_ctrl_in), 160'(exp_line));
        tick();
        bus_rsp_valid = 1'b0;
        #1;
        chk({tag, "_rsp_valid"}, 160'(cpu_rsp_valid), 160'(1));
        chk({tag, "_rsp_rdata"}, 160'(cpu_rsp_rdata), 160'(exp_rdata));
        tick();
        chk({tag, "_rsp_pulse"}, 160'(cpu_rsp_valid), 160'(0));
    endtask

    task automatic hit_resp(input string tag, input logic [31:0] exp_rdata);
        chk({tag, "_early"}, 160'(cpu_rsp_valid), 160'(0));
        tick();
        chk({tag, "_rsp_valid"}, 160'(cpu_rsp_valid), 160'(1));
        chk({tag, "_rsp_rdata"}, 160'(cpu_rsp_rdata), 160'(exp_rdata));
        chk({tag, "_rsp_no_we"}, 160'(ctrl_valid), 160'(0));
        tick();
        chk({tag, "_rsp_pulse"}, 160'(cpu_rsp_valid), 160'(0));
    endtask

    initial begin
        int req_before;

        #2;
        chk("rst_ready", 160'(cpu_req_ready), 160'(1));
        chk("rst_rsp", 160'(cpu_rsp_valid), 160'(0));
        chk("rst_bus_req", 160'(bus_req), 160'(0));
        chk("rst_ctrl_valid", 160'(ctrl_valid), 160'(0));
        chk("rst_addr_ctrl", 160'(addr_ctrl), 160'(0));
        tick();
        tick();
        reset_n = 1'b1;
        tick();

        // Cold load miss.
        issue(1'b0, 32'h0000_0104, 32'h0);
        chk("cold_addr_ctrl", 160'(addr_ctrl), 160'(28'h10));
        wait_bus("cold_rd", BUS_RD, 28'h10);
        grant();
        fill("cold", FILL1, mk_line(S, 26'h4, FILL1), 32'hA5A5_0001);

        // Load hit; stray fill data must be ignored.
        req_before    = n_req_cyc;
        bus_rsp_valid = 1'b1;
        bus_rsp_data  = '1;
        issue(1'b0, 32'h0000_0104, 32'h0);
        chk("hit_lookup_no_we", 160'(ctrl_valid), 160'(0));
        hit_resp("ld_hit", 32'hA5A5_0001);
        bus_rsp_valid = 1'b0;
        chk("ld_hit_no_bus", 160'(n_req_cyc - req_before), 160'(0));

        // Store to S line goes out as RDX.
        issue(1'b1, 32'h0000_0108, 32'hDEAD_BEEF);
        wait_bus("st_rdx", BUS_RDX, 28'h10);
        grant();
        fill("st_rdx", FILL1, mk_line(M, 26'h4, D_RDX), 32'h0);

        // Store hit in M: merge with no bus traffic.
        req_before = n_req_cyc;
        issue(1'b1, 32'h0000_010C, 32'h0000_1234);
        chk("st_hit_we", 160'(ctrl_valid), 160'(1));
        chk("st_hit_line", 160'(cacheline_ctrl_in), 160'(mk_line(M, 26'h4, D_HIT)));
        hit_resp("st_hit", 32'h0);
        chk("st_hit_no_bus", 160'(n_req_cyc - req_before), 160'(0));

        // Conflict load evicts the dirty line first.
        issue(1'b0, 32'h0000_0204, 32'h0);
        wait_bus("evict_wb", BUS_WB, 28'h10);
        chk("evict_wdata", 160'(bus_wdata), 160'(D_HIT));
        bus_gnt = 1'b1;
        #1;
        chk("evict_inv_we", 160'(ctrl_valid), 160'(1));
        chk("evict_inv_line", 160'(cacheline_ctrl_in), 160'(mk_line(I, 26'h4, D_HIT)));
        tick();
        bus_gnt = 1'b0;
        #1;
        wait_bus("evict_rd", BUS_RD, 28'h20);
        grant();
        fill("evict", FILL3, mk_line(S, 26'h8, FILL3), 32'h4444_0001);

        // Make 0x20 dirty, then abort its writeback via a snoop downgrade.
        issue(1'b1, 32'h0000_0204, 32'h5555_5555);
        wait_bus("dirty_rdx", BUS_RDX, 28'h20);
        grant();
        fill("dirty", FILL3, mk_line(M, 26'h8, D_ST6), 32'h0);

        req_before = n_wb_iss;
        issue(1'b0, 32'h0000_0104, 32'h0);
        wait_bus("snp_wb", BUS_WB, 28'h20);
        chk("snp_wdata", 160'(bus_wdata), 160'(D_ST6));
        tick();
        chk("snp_wb_hold", 160'(bus_req), 160'(1));
        snoop_idx  = 2'd0;
        snoop_line = mk_line(S, 26'h8, D_ST6);
        snoop_we   = 1'b1;
        #1;
        chk("snp_drop_req", 160'(bus_req), 160'(0));
        chk("snp_no_we", 160'(ctrl_valid), 160'(0));
        tick();
        snoop_we = 1'b0;
        #1;
        wait_bus("snp_rd", BUS_RD, 28'h10);
        chk("snp_no_wb_issued", 160'(n_wb_iss - req_before), 160'(0));
        grant();
        fill("snp", FILL1, mk_line(S, 26'h4, FILL1), 32'hA5A5_0001);

        // Reset while waiting for fill data.
        issue(1'b0, 32'h0000_0304, 32'h0);
        wait_bus("rst_rd", BUS_RD, 28'h30);
        grant();
        reset_n = 1'b0;
        #1;
        chk("mid_rst_ready", 160'(cpu_req_ready), 160'(1));
        chk("mid_rst_bus_req", 160'(bus_req), 160'(0));
        chk("mid_rst_addr", 160'(addr_ctrl), 160'(0));
        bus_rsp_valid = 1'b1;
        bus_rsp_data  = FILL3;
        #1;
        chk("mid_rst_we", 160'(ctrl_valid), 160'(0));
        tick();
        chk("mid_rst_rsp", 160'(cpu_rsp_valid), 160'(0));
        tick();
        bus_rsp_valid = 1'b0;
        reset_n       = 1'b1;
        #1;
        chk("post_rst_rsp", 160'(cpu_rsp_valid), 160'(0));
        issue(1'b0, 32'h0000_0104, 32'h0);
        hit_resp("post_rst", 32'hA5A5_0001);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule

// File: doc/l1_ctrl.md
Name: l1_ctrl

Overview:
- Processor-side controller for one core's L1 storage array.
- Accepts single-word load/store requests, performs the lookup and read-modify-write through the array's controller port, and resolves misses over the shared coherence bus using the MSI protocol.
- Evicts dirty (M) victims with a writeback. One request is outstanding at a time.
- Sits between the core pipeline, the L1 array, and the bus arbiter. The snooper owns the array's snoop port.

Parameters:
- WORD_BITS, 32, width of a processor data word.
- Constraint: `OFFSET_BITS >= log2(WORD_BITS/8)`.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous, active-low reset
- cpu_req_valid  in  1  processor request valid
- cpu_req_ready  out  1  controller accepts a request; high only in IDLE
- cpu_req_we  in  1  1 = store, 0 = load
- cpu_req_addr  in  `ADDR_BITS  byte address
- cpu_req_wdata  in  WORD_BITS  store data
- cpu_rsp_valid  out  1  one-cycle completion pulse, for both loads and stores
- cpu_rsp_rdata  out  WORD_BITS  load data; valid with cpu_rsp_valid
- addr_ctrl  out  `ADDR_BITS-`OFFSET_BITS  line address driven to the array's controller port
- cacheline_ctrl_out  in  l1_cacheline_t  array read data; combinational, already reflects a same-cycle snoop update
- cacheline_ctrl_in  out  l1_cacheline_t  line written to the array
- ctrl_valid  out  1  array write enable; the write commits at the next clk edge
- bus_req  out  1  bus request to the arbiter; may be withdrawn before bus_gnt
- bus_gnt  in  1  grant; a transaction issues in the cycle where bus_req && bus_gnt
- bus_cmd  out  bus_cmd_t  BUS_RD, BUS_RDX or BUS_WB
- bus_addr  out  `ADDR_BITS-`OFFSET_BITS  transaction line address
- bus_wdata  out  `LINE_BITS  writeback data
- bus_rsp_valid  in  1  fill data valid (RD/RDX only)
- bus_rsp_data  in  `LINE_BITS  fill data

Behaviour:
- Address fields:
  - line address = addr[`ADDR_BITS-1:`OFFSET_BITS]
  - index = low `L1_INDEX_BITS of the line address
  - tag = remaining upper bits
  - word select = addr[`OFFSET_BITS-1:log2(WORD_BITS/8)]
- The request is latched on cpu_req_valid && cpu_req_ready. addr_ctrl = latched line address in every state except IDLE.
- Reset (asynchronous, any state): state = IDLE. All outputs 0 except cpu_req_ready = 1. The latched request is discarded and no response is issued for it.
- FSM: IDLE, LOOKUP, WB, MISS_REQ, MISS_WAIT, RESP.
- IDLE → LOOKUP on accept.
- LOOKUP makes a single-cycle decision from cacheline_ctrl_out (L). Hit means L.state != I and L.tag matches.
  - Load hit (S or M): latch the selected word → RESP.
  - Store hit in M: ctrl_valid = 1, writing L with the word merged, state M → RESP.
  - Store to an S line: treated as a miss with cmd RDX. There is no upgrade command.
  - Miss, or store to S:
    - L.state == M and the tag differs → WB.
    - Otherwise → MISS_REQ, with cmd RD for a load and RDX for a store.
- WB:
  - bus_req = 1, bus_cmd = BUS_WB, bus_addr = {L.tag, index}, bus_wdata = live cacheline_ctrl_out data.
  - Each cycle the line is re-checked. If it is no longer M with the victim tag (a snoop flushed or downgraded it), drop bus_req the same cycle → MISS_REQ.
  - On grant: ctrl_valid = 1, writing L with state I → MISS_REQ.
- MISS_REQ: bus_req = 1 with the RD/RDX command and the request line address. On grant → MISS_WAIT.
- MISS_WAIT: on bus_rsp_valid, ctrl_valid = 1 writing:
  - tag = request tag
  - data = bus_rsp_data, with the store word merged for RDX
  - state = S for RD, M for RDX
  - The load word is latched from bus_rsp_data → RESP.
- RESP: cpu_rsp_valid = 1 for one cycle. cpu_rsp_rdata holds the latched word, and 0 for stores → IDLE.
- Latency from the accept edge:
  - Hit: response in cycle +2.
  - Miss: response the cycle after bus_rsp_valid.
- ctrl_valid is asserted for at most one cycle per write and never in IDLE or RESP.
- cpu_req_ready = 0 from the accept edge until the return to IDLE.
- bus_rsp_valid outside MISS_WAIT is ignored.

Decomposition:
- Package cache_pkg holds:
  - l1_state_t (M, S, I) and l1_cacheline_t
  - bus_cmd_t {BUS_RD, BUS_RDX, BUS_WB}
  - l1_ctrl_state_t
  - LINE_BITS = 8 << `OFFSET_BITS
  - tag/index extraction functions
- Sub-module l1_word_mux: combinational word extract from a line and word insert into a line, driven by the word select. It is shared by the hit path and the fill path.

Test Plan:
Configuration for all scenarios: `OFFSET_BITS = 4, `L1_INDEX_BITS = 2, WORD_BITS = 32.
- Cold load to 0x0000_0104: bus_cmd = BUS_RD on line 0x10. Inject rsp data word1 = 0xA5A5_0001 → the line is written S with tag 0x4. cpu_rsp_rdata = 0xA5A5_0001 one cycle after rsp.
- Repeat the load to 0x104: no bus_req. cpu_rsp_valid is asserted 2 cycles after accept.
- Store 0xDEAD_BEEF to 0x108 while the line is S: BUS_RDX is issued. After fill, the line is M with word2 = 0xDEAD_BEEF. A following store hit to 0x10C writes 0x1234 with no bus traffic.
- Load to 0x0000_0204, which maps to the same index as the dirty M line: BUS_WB is issued first with bus_addr 0x10 and the M data; the victim is written I on grant; then BUS_RD for 0x20.
- During WB with bus_gnt held 0, the snooper writes the victim to S: bus_req drops the same cycle, no BUS_WB issues, and BUS_RD for 0x20 follows.
- Assert reset_n = 0 in MISS_WAIT: outputs go to reset values immediately with no cpu_rsp_valid. After release, a new request is accepted and serviced normally.
